// File: rtl/pad_conditioner.sv
// -----------------------------------------------------------------------------
// pad_conditioner
//
// Input-side conditioner for the four dance-pad buttons. Raw, asynchronous pad
// contacts are synchronized, polarity-corrected and debounced per channel to
// give clean single-cycle press pulses and debounced held levels for the
// arrow/game logic.
//
// Bit order matches the arrow bus: {left, up, down, right} = [3:0].
//
// Ports
//   clk_i      in   1  system/pixel clock, the only clock
//   reset_n_i  in   1  synchronous active-low reset
//   frame_i    in   1  one-cycle start-of-frame strobe (repeat build only)
//   pad_i      in   4  raw pad contacts, asynchronous
//   press_o    out  4  one-cycle press pulse per channel
//   held_o     out  4  debounced pressed level per channel
//
// Build option
//   PAD_REPEAT_EN  when defined, a held button emits auto-repeat pulses counted
//                  in frames (REPEAT_DELAY for the first, REPEAT_PERIOD after).
//                  When undefined, exactly one pulse per debounced press.
// -----------------------------------------------------------------------------
module pad_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DEBOUNCE_W      = 16,
  parameter int PAD_ACTIVE_LOW  = 1,
  parameter int REPEAT_DELAY    = 30,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       frame_i,
  input  logic [3:0] pad_i,
  output logic [3:0] press_o,
  output logic [3:0] held_o
);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_e;

  // Inactive pad level: what the synchronizer holds while nothing is pressed.
  localparam logic                  PAD_IDLE = (PAD_ACTIVE_LOW != 0);
  localparam logic [DEBOUNCE_W-1:0] CNT_MAX  = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Input stage: two synchronizer flops per bit, then a registered
  // polarity-corrected "active" level. The extra act register keeps the
  // pad-to-state path one flop long, giving a fixed DEBOUNCE_CYCLES+3 latency.
  // ---------------------------------------------------------------------------
  logic [3:0] sync1_q, sync2_q, act_q;
  logic [3:0] act_d;

  always_comb begin
    act_d = sync2_q ^ {4{PAD_IDLE}};
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, independent of statement order.
    if (!reset_n_i) begin
      sync1_q <= {4{PAD_IDLE}};
      sync2_q <= {4{PAD_IDLE}};
      act_q   <= '0;
    end else begin
      sync1_q <= pad_i;
      sync2_q <= sync1_q;
      act_q   <= act_d;
    end
  end

`ifndef PAD_REPEAT_EN
  // Without auto-repeat the frame strobe and repeat timing have no consumer.
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
  logic unused_frame;
  assign unused_frame = frame_i;
`endif

  // ---------------------------------------------------------------------------
  // Per-channel debounce FSM: state register / next-state / output processes.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < 4; i++) begin : g_ch
    state_e                  state_q, state_d;
    logic [DEBOUNCE_W-1:0]   cnt_q, cnt_d;
    logic                    press_q, press_d;
    logic                    held_q, held_d;
`ifdef PAD_REPEAT_EN
    localparam logic [5:0]   REP_DELAY  = 6'(REPEAT_DELAY);
    localparam logic [5:0]   REP_PERIOD = 6'(REPEAT_PERIOD);
    logic [5:0]              fcnt_q, fcnt_d;
    logic                    rep_q, rep_d;
    logic                    rep_fire;
    logic [5:0]              rep_cmp;
`endif

    // State register (also holds the counters and the output flops).
    always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
        state_q <= RELEASED;
        cnt_q   <= '0;
        press_q <= 1'b0;
        held_q  <= 1'b0;
`ifdef PAD_REPEAT_EN
        fcnt_q  <= '0;
        rep_q   <= 1'b0;
`endif
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        press_q <= press_d;
        held_q  <= held_d;
`ifdef PAD_REPEAT_EN
        fcnt_q  <= fcnt_d;
        rep_q   <= rep_d;
`endif
      end
    end

    // Next-state logic. The counter only advances while it is below CNT_MAX,
    // because reaching CNT_MAX always leaves the checking state.
    always_comb begin
      // NOTE: defaults first so every path assigns every output of this
      // block; a missing branch would otherwise infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        RELEASED: begin
          if (act_q[i]) begin
            state_d = PRESS_CHK;
            cnt_d   = '0;
          end
        end
        PRESS_CHK: begin
          if (!act_q[i]) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = PRESSED;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!act_q[i]) begin
            state_d = RELEASE_CHK;
            cnt_d   = '0;
          end
        end
        RELEASE_CHK: begin
          if (act_q[i]) begin
            // Release was a bounce: resume the held press without a pulse.
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = RELEASED;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
        end
      endcase
    end

    // Output logic: press pulse on an accepted press (or repeat), held level
    // tracks the next state so it rises together with the press pulse.
    always_comb begin
      held_d = (state_d == PRESSED) || (state_d == RELEASE_CHK);
`ifdef PAD_REPEAT_EN
      rep_cmp  = rep_q ? REP_PERIOD : REP_DELAY;
      rep_fire = 1'b0;
      fcnt_d   = fcnt_q;
      rep_d    = rep_q;
      if (state_d == RELEASED) begin
        fcnt_d = '0;
        rep_d  = 1'b0;
      end else if (state_d == PRESSED && state_q != PRESSED) begin
        fcnt_d = '0;
      end else if (frame_i &&
                   (state_q == PRESSED || state_q == RELEASE_CHK)) begin
        if (fcnt_q + 6'd1 == rep_cmp) begin
          rep_fire = 1'b1;
          fcnt_d   = '0;
          rep_d    = 1'b1;
        end else begin
          fcnt_d = fcnt_q + 6'd1;
        end
      end
      press_d = ((state_q == PRESS_CHK) && (state_d == PRESSED)) || rep_fire;
`else
      press_d = (state_q == PRESS_CHK) && (state_d == PRESSED);
`endif
    end

    assign press_o[i] = press_q;
    assign held_o[i]  = held_q;
  end

endmodule

// File: tb/tb_pad_conditioner.sv
// -----------------------------------------------------------------------------
// tb_pad_conditioner
//
// Directed bench for pad_conditioner with DEBOUNCE_CYCLES=4, active-low pads.
// A press first sampled at edge 0 pulses after edge 7; a release drops held
// after edge 7. Inputs change 1 ns after a rising edge, outputs are sampled at
// the same point, so "after edge k" is what each check observes.
// -----------------------------------------------------------------------------
module tb_pad_conditioner;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       frame_i;
  logic [3:0] pad_i;
  logic [3:0] press_o;
  logic [3:0] held_o;

  int vectors     = 0;
  int miscompares = 0;

  pad_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .DEBOUNCE_W      (16),
    .PAD_ACTIVE_LOW  (1),
    .REPEAT_DELAY    (3),
    .REPEAT_PERIOD   (2)
  ) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .frame_i   (frame_i),
    .pad_i     (pad_i),
    .press_o   (press_o),
    .held_o    (held_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Idle all pads and let every channel settle back to RELEASED.
  task automatic settle();
    pad_i = 4'b1111;
    for (int k = 0; k < 10; k++) tick();
  endtask

  initial begin
    reset_n_i = 1'b0;
    frame_i   = 1'b0;
    pad_i     = 4'b1111;

    // Reset state
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("reset_press_%0d", k), press_o, 4'b0000);
      check($sformatf("reset_held_%0d", k), held_o, 4'b0000);
    end
    reset_n_i = 1'b1;
    for (int k = 0; k < 3; k++) tick();

    // Clean press on left (bit 3): pulse only after edge 7
    pad_i = 4'b0111;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("clean_press_%0d", k), press_o, (k == 7) ? 4'b1000 : 4'b0000);
      check($sformatf("clean_held_%0d", k), held_o, (k >= 7) ? 4'b1000 : 4'b0000);
    end
    // Clean release: held falls after edge 7
    pad_i = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      tick();
      check($sformatf("clean_rel_held_%0d", k), held_o, (k < 7) ? 4'b1000 : 4'b0000);
      check($sformatf("clean_rel_press_%0d", k), press_o, 4'b0000);
    end
    settle();

    // Bounce reject on down (bit 2): low 3, high 1, repeated
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) begin
        pad_i = (k < 3) ? 4'b1011 : 4'b1111;
        tick();
        check($sformatf("bounce_press_%0d_%0d", r, k), press_o, 4'b0000);
        check($sformatf("bounce_held_%0d_%0d", r, k), held_o, 4'b0000);
      end
    end
    pad_i = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("bounce_tail_%0d", k), held_o | press_o, 4'b0000);
    end

    // Release glitch on up (bit 1)
    pad_i = 4'b1101;
    for (int k = 0; k < 10; k++) tick();
    check("glitch_pre_held", held_o, 4'b0010);
    pad_i = 4'b1111;
    tick();
    tick();
    pad_i = 4'b1101;
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("glitch_held_%0d", k), held_o, 4'b0010);
      check($sformatf("glitch_press_%0d", k), press_o, 4'b0000);
    end
    pad_i = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      tick();
      check($sformatf("glitch_rel_held_%0d", k), held_o, (k < 7) ? 4'b0010 : 4'b0000);
    end
    settle();

    // Simultaneous press on all four
    pad_i = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("simul_press_%0d", k), press_o, (k == 7) ? 4'b1111 : 4'b0000);
    end
    check("simul_held", held_o, 4'b1111);
    settle();

    // Staggered presses one edge apart -> pulses in consecutive cycles
    pad_i = 4'b0111;
    for (int k = 0; k < 13; k++) begin
      logic [3:0] exp;
      tick();
      if (k == 0) pad_i = 4'b0011;
      if (k == 1) pad_i = 4'b0001;
      if (k == 2) pad_i = 4'b0000;
      case (k)
        7:       exp = 4'b1000;
        8:       exp = 4'b0100;
        9:       exp = 4'b0010;
        10:      exp = 4'b0001;
        default: exp = 4'b0000;
      endcase
      check($sformatf("stagger_press_%0d", k), press_o, exp);
    end
    settle();

    // Reset while left is PRESSED, pad kept held through and after reset
    pad_i = 4'b0111;
    for (int k = 0; k < 10; k++) tick();
    check("rstmid_pre_held", held_o, 4'b1000);
    reset_n_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("rstmid_press_%0d", k), press_o, 4'b0000);
      check($sformatf("rstmid_held_%0d", k), held_o, 4'b0000);
    end
    reset_n_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("rstmid_re_press_%0d", k), press_o, (k == 7) ? 4'b1000 : 4'b0000);
      check($sformatf("rstmid_re_held_%0d", k), held_o, (k >= 7) ? 4'b1000 : 4'b0000);
    end
    settle();

`ifdef PAD_REPEAT_EN
    // Auto-repeat on right (bit 0): pulses on frames 3, 5, 7 after the press
    pad_i = 4'b1110;
    for (int k = 0; k < 8; k++) tick();
    check("rep_initial_held", held_o, 4'b0001);
    for (int f = 1; f <= 8; f++) begin
      frame_i = 1'b1;
      tick();
      frame_i = 1'b0;
      check($sformatf("rep_frame_%0d", f), press_o,
            (f == 3 || f == 5 || f == 7) ? 4'b0001 : 4'b0000);
      tick();
      tick();
    end
    pad_i = 4'b1111;
    for (int k = 0; k < 9; k++) tick();
    for (int f = 1; f <= 4; f++) begin
      frame_i = 1'b1;
      tick();
      frame_i = 1'b0;
      check($sformatf("rep_after_rel_%0d", f), press_o, 4'b0000);
      tick();
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pad_conditioner.md
# pad_conditioner

Input-side conditioner for the four dance-pad buttons on the iCE40 DDR build. It takes raw asynchronous pad contacts and produces what the arrow/game logic consumes on its button inputs:
- clean single-cycle press pulses;
- debounced held levels.

Bit order matches the arrow bus, `{left, up, down, right}` = bits `[3:0]`. Each channel has its own 2-flop synchronizer, debounce state machine and counter.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 50000: clock cycles a new level must be stable before it is accepted (2 ms at 25 MHz); legal range 2 … 2^`DEBOUNCE_W`.
- `DEBOUNCE_W`, 16: debounce counter width.
- `PAD_ACTIVE_LOW`, 1: 1 means a pad reads 0 when pressed (pulled-up contacts).
- `REPEAT_DELAY`, 30: frames held before the first repeat pulse (repeat build only); legal range 1 … 63.
- `REPEAT_PERIOD`, 8: frames between later repeat pulses (repeat build only); legal range 1 … 63.

Ports:
- `clk_i`, input, 1: pixel/system clock; the only clock.
- `reset_n_i`, input, 1: reset; synchronous, active-low.
- `frame_i`, input, 1: one-cycle start-of-frame strobe from the display timing.
- `pad_i`, input, 4: raw pad contacts, asynchronous, polarity set by `PAD_ACTIVE_LOW`.
- `press_o`, output, 4: one-cycle press pulse per channel; drives the game's button inputs.
- `held_o`, output, 4: debounced pressed level per channel.

## Operation
Input stage:
- `pad_i` passes through 2 synchronizer flops per bit.
- The synchronized value is XORed with `PAD_ACTIVE_LOW` to give `act`.

Per-channel state machine (2-bit state, `DEBOUNCE_W`-bit counter `cnt`):
- `RELEASED`:
  - `act`=1 → go to `PRESS_CHK`, `cnt`<=0.
- `PRESS_CHK`:
  - `act`=0 → go to `RELEASED`, `cnt`<=0.
  - `act`=1 and `cnt`==`DEBOUNCE_CYCLES`-1 → go to `PRESSED`, `press_o`[i]<=1.
  - otherwise `cnt`++.
- `PRESSED`:
  - `act`=0 → go to `RELEASE_CHK`, `cnt`<=0.
- `RELEASE_CHK`:
  - `act`=1 → go back to `PRESSED`, `cnt`<=0, no pulse.
  - `act`=0 and `cnt`==`DEBOUNCE_CYCLES`-1 → go to `RELEASED`.
  - otherwise `cnt`++.

Outputs:
- `held_o`[i] = 1 exactly when the state is `PRESSED` or `RELEASE_CHK`. It is registered, from the state register.
- `press_o`[i] is a register that defaults to 0 every cycle. It is only set on the transitions named above, or by a repeat event.
- Channels are fully independent, with no arbitration. Any combination of `press_o` bits may be high in the same cycle; the consumer resolves priority.
- The counter never wraps. It saturates at `DEBOUNCE_CYCLES`-1 by construction.

## Timing
Reset (`reset_n_i`=0 at a clock edge):
- all states go to `RELEASED`, all `cnt` to 0;
- synchronizer flops load the inactive level (`PAD_ACTIVE_LOW`);
- `press_o`=0, `held_o`=0, repeat counters 0.

Reset mid-press:
- No pulse is emitted during reset or on the first edge after it.
- If the pad is still held after reset, a fresh press is debounced from scratch.

Latency:
- A clean assertion of `pad_i` first sampled at edge 0 reaches `act` at edge 2 and enters `PRESS_CHK` at edge 3.
- `press_o` is high for exactly the cycle following edge `DEBOUNCE_CYCLES`+3.
- `held_o` rises in the same cycle as `press_o`.

Release latency:
- `held_o` falls `DEBOUNCE_CYCLES`+3 edges after a clean deassertion.

Glitches:
- A bounce shorter than `DEBOUNCE_CYCLES` cycles, in either direction, produces no output change.
- The debounce count restarts from 0 after every bounce.

Frame strobe:
- `frame_i` is ignored in non-repeat builds.

## Configuration
Macro `PAD_REPEAT_EN`. When defined:
- Each channel has a 6-bit frame counter `fcnt`.
- `fcnt` is cleared on entry to `PRESSED` and counts `frame_i` pulses while in `PRESSED` or `RELEASE_CHK`.
- On a `frame_i` edge where `fcnt`+1 == `REPEAT_DELAY`: `press_o`[i]<=1 for one cycle and `fcnt`<=0; the channel enters repeat phase.
- In repeat phase, `REPEAT_PERIOD` replaces `REPEAT_DELAY` as the compare value.
- Leaving to `RELEASED` clears `fcnt` and the repeat phase.

When not defined:
- No frame counter exists.
- Exactly one `press_o` pulse is emitted per debounced press.
- `REPEAT_DELAY` and `REPEAT_PERIOD` are unused.

## Test plan
- Clean press: `PAD_ACTIVE_LOW`=1, `DEBOUNCE_CYCLES`=4. Drive `pad_i`[3]=0 held from edge 0 → `press_o`=4'b1000 for one cycle after edge 7 only; `held_o`[3]=1 from that cycle.
- Bounce reject: toggle `pad_i`[2] low for 3 cycles, high for 1, repeating, with `DEBOUNCE_CYCLES`=4 → `press_o` and `held_o` stay 0.
- Release glitch: while pressed, release `pad_i`[1] for 2 cycles then press again → `held_o`[1] stays 1, no second pulse. A full release → `held_o`[1] falls 7 edges after the release.
- Simultaneous: all four pads asserted on the same edge → `press_o`=4'b1111 in a single cycle. Pads asserted one cycle apart → pulses in consecutive cycles.
- Reset mid-operation: assert `reset_n_i`=0 while the left pad is held in `PRESSED`, for 2 cycles → outputs go to 0 with no pulse. After release of reset, with the pad still held → one pulse 7 edges later.
- Repeat build: `PAD_REPEAT_EN`, `REPEAT_DELAY`=3, `REPEAT_PERIOD`=2, pad held → one initial pulse, then pulses on the 3rd, 5th and 7th `frame_i` after the press. No pulses after release.
